// File: rtl/button_event_pkg.sv
// button_event_pkg: event encoding shared by button_event_ctrl and its event FIFO.
package button_event_pkg;

  // Wide enough for the largest supported button count (16 lines).
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  typedef struct packed {
    evt_type_e             kind;
    logic [MAX_IDX_W-1:0]  index;
  } evt_t;

  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/button_event_fifo.sv
// button_event_fifo: show-ahead synchronous FIFO of evt_t; the head entry is presented
// whenever the FIFO is not empty. A push into a full FIFO is accepted if a pop happens that cycle.
module button_event_fifo
  import button_event_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  evt_t                     wr_data,
  input  logic                     rd_en,
  output evt_t                     rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  evt_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;

  // NOTE: combinational blocks use blocking '=' and give every output a value on every path, so no latch is inferred.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = rd_en & ~empty;
    push     = wr_en & (~full | pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // An empty FIFO presents an all-zero head rather than stale storage.
    rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    level    = count_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q and an empty head reads as zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into PRESS/RELEASE events queued in a FIFO with a level IRQ.
// Long-press (LONG) detection is built only when BTN_EVT_LONG_PRESS_EN is defined.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int TICK_DIV     = 100000,
  parameter  int TICK_WIDTH   = 17,
  parameter  int LONG_TICKS   = 1000,
  parameter  int LONG_WIDTH   = 10,
  localparam int IDX_W        = idx_width(WIDTH),
  localparam int FIFO_DEPTH_W = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        btn_in,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [1:0]              evt_type,
  output logic [IDX_W-1:0]        evt_index,
  output logic [FIFO_DEPTH_W:0]   evt_level,
  input  logic                    irq_en,
  output logic                    irq,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  logic [WIDTH-1:0] btn_q, btn_d;
  logic [WIDTH-1:0] pend_press_q, pend_press_d;
  logic [WIDTH-1:0] pend_rel_q, pend_rel_d;
  logic [WIDTH-1:0] pend_long_q, pend_long_d;
  logic [WIDTH-1:0] rise, fall, long_set;
  logic [WIDTH-1:0] sel_press, sel_rel, sel_long;
  logic [WIDTH-1:0] clr_press, clr_rel, clr_long;
  logic             push_valid, push_ready, pop, drop, found;
  logic             ovf_q, ovf_d, irq_q, irq_d;
  logic             fifo_full, fifo_empty;
  evt_t             push_evt, head_evt;

`ifdef BTN_EVT_LONG_PRESS_EN
  logic [TICK_WIDTH-1:0]             presc_q, presc_d;
  logic [WIDTH-1:0][LONG_WIDTH-1:0]  hold_q, hold_d;
  logic                              tick;

  always_comb begin
    tick     = (presc_q == TICK_WIDTH'(TICK_DIV - 1));
    presc_d  = tick ? '0 : presc_q + TICK_WIDTH'(1);
    hold_d   = hold_q;
    long_set = '0;
    // Per-line hold counter: cleared while released, saturates at LONG_TICKS so LONG fires once per hold.
    for (int i = 0; i < WIDTH; i++) begin
      if (!btn_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != LONG_WIDTH'(LONG_TICKS)) begin
        hold_d[i]   = hold_q[i] + LONG_WIDTH'(1);
        long_set[i] = (hold_q[i] == LONG_WIDTH'(LONG_TICKS - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      hold_q  <= '0;
    end else begin
      presc_q <= presc_d;
      hold_q  <= hold_d;
    end
  end
`else
  assign long_set = '0;

  logic unused_cfg;
  assign unused_cfg = ^{32'(TICK_DIV), 32'(TICK_WIDTH), 32'(LONG_TICKS), 32'(LONG_WIDTH)};
`endif

  always_comb begin
    btn_d      = btn_in;
    rise       = btn_in & ~btn_q;
    fall       = ~btn_in & btn_q;
    pop        = evt_valid & evt_ready;
    push_ready = ~fifo_full | pop;

    found     = 1'b0;
    push_evt  = '0;
    sel_press = '0;
    sel_rel   = '0;
    sel_long  = '0;
    // Lowest index wins; within a line PRESS precedes LONG precedes RELEASE.
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && (pend_press_q[i] || pend_long_q[i] || pend_rel_q[i])) begin
        found          = 1'b1;
        push_evt.index = MAX_IDX_W'(i);
        if (pend_press_q[i]) begin
          push_evt.kind = EVT_PRESS;
          sel_press[i]  = 1'b1;
        end else if (pend_long_q[i]) begin
          push_evt.kind = EVT_LONG;
          sel_long[i]   = 1'b1;
        end else begin
          push_evt.kind = EVT_RELEASE;
          sel_rel[i]    = 1'b1;
        end
      end
    end
    push_valid = found;

    clr_press = sel_press & {WIDTH{push_ready}};
    clr_rel   = sel_rel   & {WIDTH{push_ready}};
    clr_long  = sel_long  & {WIDTH{push_ready}};

    // A new edge on a flag pushed this same cycle re-arms it; otherwise it collides and is dropped.
    pend_press_d = (pend_press_q & ~clr_press) | rise;
    pend_rel_d   = (pend_rel_q   & ~clr_rel)   | fall;
    pend_long_d  = (pend_long_q  & ~clr_long)  | long_set;

    drop = |((rise     & pend_press_q & ~clr_press) |
             (fall     & pend_rel_q   & ~clr_rel)   |
             (long_set & pend_long_q  & ~clr_long));

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    irq_d = evt_valid & irq_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q        <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      pend_long_q  <= '0;
      ovf_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      btn_q        <= btn_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      pend_long_q  <= pend_long_d;
      ovf_q        <= ovf_d;
      irq_q        <= irq_d;
    end
  end

  button_event_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_valid),
    .wr_data (push_evt),
    .rd_en   (evt_ready),
    .rd_data (head_evt),
    .level   (evt_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_type  = head_evt.kind;
  assign evt_index = head_evt.index[IDX_W-1:0];
  assign irq       = irq_q;
  assign ovf       = ovf_q;

  logic unused_head;
  assign unused_head = ^head_evt.index;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: scoreboard bench for button_event_ctrl; a 4-line instance covers queuing,
// overflow and reset, a 2-line fast-tick instance covers long-press (BTN_EVT_LONG_PRESS_EN aware).
module tb_button_event_ctrl;

  localparam logic [1:0] T_PRESS = 2'd0;
  localparam logic [1:0] T_REL   = 2'd1;
  localparam logic [1:0] T_LONG  = 2'd2;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b1;

  logic [3:0] btn;
  logic       valid, ready;
  logic [1:0] etype;
  logic [1:0] eidx;
  logic [2:0] level;
  logic       irq_en, irq, ovf, ovf_clr;

  logic [1:0] l_btn;
  logic       l_valid, l_ready;
  logic [1:0] l_type;
  logic [0:0] l_idx;
  logic [2:0] l_level;
  logic       l_irq_en, l_irq, l_ovf, l_ovf_clr;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t lsb_q[$];

  button_event_ctrl #(
    .WIDTH(4), .FIFO_DEPTH(4), .TICK_DIV(1000), .TICK_WIDTH(10), .LONG_TICKS(1000), .LONG_WIDTH(10)
  ) u_main (
    .clk(clk), .reset_n(reset_n), .btn_in(btn),
    .evt_valid(valid), .evt_ready(ready), .evt_type(etype), .evt_index(eidx), .evt_level(level),
    .irq_en(irq_en), .irq(irq), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  button_event_ctrl #(
    .WIDTH(2), .FIFO_DEPTH(4), .TICK_DIV(4), .TICK_WIDTH(2), .LONG_TICKS(3), .LONG_WIDTH(2)
  ) u_long (
    .clk(clk), .reset_n(reset_n), .btn_in(l_btn),
    .evt_valid(l_valid), .evt_ready(l_ready), .evt_type(l_type), .evt_index(l_idx), .evt_level(l_level),
    .irq_en(l_irq_en), .irq(l_irq), .ovf(l_ovf), .ovf_clr(l_ovf_clr)
  );

  function automatic exp_t mk(input logic [1:0] t, input int idx);
    exp_t e;
    e.t   = t;
    e.idx = 4'(idx);
    return e;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pops the main scoreboard as the DUT presents events, then expects an idle, empty FIFO.
  task automatic drain_main(input string name, input int budget);
    exp_t e;
    int   waited;
    waited = 0;
    @(posedge clk);
    #1;
    ready = 1'b1;
    while (sb_q.size() > 0 && waited < budget) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        e = sb_q.pop_front();
        total++;
        if (etype !== e.t || eidx !== e.idx[1:0]) begin
          bad++;
          $display("FAIL %s_event: got type=%0d idx=%0d, want type=%0d idx=%0d", name, etype, eidx, e.t, e.idx);
        end
      end
      waited++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d expected events never appeared", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL %s_idle: evt_valid=%b level=%0d, want 0/0", name, valid, level);
    end
  endtask

  // Observes the long-press instance for n cycles (evt_ready held high) against its scoreboard.
  task automatic watch_long(input string name, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (l_valid === 1'b1) begin
        total++;
        if (lsb_q.size() == 0) begin
          bad++;
          $display("FAIL %s_extra: got type=%0d idx=%0d, want no event", name, l_type, l_idx);
        end else begin
          e = lsb_q.pop_front();
          if (l_type !== e.t || l_idx !== e.idx[0:0]) begin
            bad++;
            $display("FAIL %s_event: got type=%0d idx=%0d, want type=%0d idx=%0d", name, l_type, l_idx, e.t, e.idx);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    btn = '0; ready = 1'b0; irq_en = 1'b0; ovf_clr = 1'b0;
    l_btn = '0; l_ready = 1'b1; l_irq_en = 1'b0; l_ovf_clr = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({valid, etype, eidx, level, irq, ovf} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want all zero", {valid, etype, eidx, level, irq, ovf});
    end
    tick(3);
    reset_n = 1'b1;
    tick(2);
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0 || l_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: valid=%b level=%0d ovf=%b l_valid=%b, want 0", valid, level, ovf, l_valid);
    end
  endtask

  task automatic test_press_release;
    ready = 1'b0; irq_en = 1'b0;
    tick(10);
    btn[2] = 1'b1;
    sb_q.push_back(mk(T_PRESS, 2));
    @(posedge clk); @(negedge clk);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL press_early: evt_valid=%b one edge after sampling, want 0", valid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (valid !== 1'b1 || level !== 3'd1 || irq !== 1'b0) begin
      bad++;
      $display("FAIL press_latency: valid=%b level=%0d irq=%b, want 1/1/0", valid, level, irq);
    end
    drain_main("press2", 20);

    tick(30);
    btn[2] = 1'b0;
    sb_q.push_back(mk(T_REL, 2));
    @(posedge clk); @(negedge clk);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL release_early: evt_valid=%b one edge after sampling, want 0", valid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL release_latency: evt_valid=%b, want 1", valid);
    end
    drain_main("release2", 20);
  endtask

  task automatic test_simultaneous;
    tick(1);
    ready = 1'b0; irq_en = 1'b1;
    btn = 4'hF;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(T_PRESS, i));
    tick(6);
    @(negedge clk);
    total++;
    if (level !== 3'd4 || valid !== 1'b1 || irq !== 1'b1) begin
      bad++;
      $display("FAIL simul_level: level=%0d valid=%b irq=%b, want 4/1/1", level, valid, irq);
    end
    total++;
    if (etype !== sb_q[0].t || eidx !== sb_q[0].idx[1:0]) begin
      bad++;
      $display("FAIL simul_head: got type=%0d idx=%0d, want type=%0d idx=%0d", etype, eidx, sb_q[0].t, sb_q[0].idx);
    end
    tick(1);
    irq_en = 1'b0;
    tick(2);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL simul_irq_off: irq=%b with irq_en=0, want 0", irq);
    end
    drain_main("simul", 30);
  endtask

  task automatic test_overflow;
    tick(1);
    ready = 1'b0;
    btn = 4'h0;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(T_REL, i));
    tick(6);
    @(negedge clk);
    total++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_fill: level=%0d ovf=%b, want 4/0", level, ovf);
    end
    tick(1);
    btn[0] = 1'b1; sb_q.push_back(mk(T_PRESS, 0));
    tick(2);
    btn[0] = 1'b0; sb_q.push_back(mk(T_REL, 0));
    tick(2);
    btn[0] = 1'b1;
    tick(2);
    @(negedge clk);
    total++;
    if (ovf !== 1'b1 || level !== 3'd4) begin
      bad++;
      $display("FAIL ovf_set: ovf=%b level=%0d, want 1/4", ovf, level);
    end
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
    end
    tick(1);
    btn[0] = 1'b0;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop_wins: ovf=%b after drop with ovf_clr, want 1", ovf);
    end
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_reclear: ovf=%b, want 0", ovf);
    end
    drain_main("ovf", 40);
  endtask

  task automatic test_full_pop;
    exp_t e;
    tick(1);
    ready = 1'b0;
    btn = 4'hF;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(T_PRESS, i));
    tick(6);
    @(negedge clk);
    total++;
    if (level !== 3'd4) begin
      bad++;
      $display("FAIL fullpop_fill: level=%0d, want 4", level);
    end
    tick(1);
    btn[3] = 1'b0;
    sb_q.push_back(mk(T_REL, 3));
    tick(1);
    ready = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if (valid !== 1'b1 || etype !== e.t || eidx !== e.idx[1:0]) begin
      bad++;
      $display("FAIL fullpop_head: valid=%b type=%0d idx=%0d, want 1 type=%0d idx=%0d", valid, etype, eidx, e.t, e.idx);
    end
    tick(1);
    ready = 1'b0;
    @(negedge clk);
    total++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_level: level=%0d ovf=%b, want 4/0", level, ovf);
    end
    total++;
    if (etype !== sb_q[0].t || eidx !== sb_q[0].idx[1:0]) begin
      bad++;
      $display("FAIL fullpop_next: got type=%0d idx=%0d, want type=%0d idx=%0d", etype, eidx, sb_q[0].t, sb_q[0].idx);
    end
    drain_main("fullpop", 30);
  endtask

  task automatic test_long;
    tick(1);
    l_btn[1] = 1'b1;
    lsb_q.push_back(mk(T_PRESS, 1));
`ifdef BTN_EVT_LONG_PRESS_EN
    lsb_q.push_back(mk(T_LONG, 1));
`endif
    watch_long("long_hold", 20);
    l_btn[1] = 1'b0;
    lsb_q.push_back(mk(T_REL, 1));
    watch_long("long_rel", 10);
    total++;
    if (lsb_q.size() != 0) begin
      bad++;
      $display("FAIL long_missing: %0d expected events not seen", lsb_q.size());
      lsb_q.delete();
    end
    l_btn[1] = 1'b1;
    lsb_q.push_back(mk(T_PRESS, 1));
    watch_long("short_hold", 8);
    l_btn[1] = 1'b0;
    lsb_q.push_back(mk(T_REL, 1));
    watch_long("short_rel", 12);
    total++;
    if (lsb_q.size() != 0) begin
      bad++;
      $display("FAIL short_missing: %0d expected events not seen", lsb_q.size());
      lsb_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    tick(1);
    ready = 1'b0; irq_en = 1'b1;
    btn = 4'h0;
    tick(6);
    @(negedge clk);
    total++;
    if (level !== 3'd3 || irq !== 1'b1) begin
      bad++;
      $display("FAIL mid_queued: level=%0d irq=%b, want 3/1", level, irq);
    end
    #2;
    reset_n = 1'b0;
    btn = 4'b0101;
    #1;
    total++;
    if ({valid, etype, eidx, level, irq, ovf} !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b, want all zero", {valid, etype, eidx, level, irq, ovf});
    end
    tick(2);
    reset_n = 1'b1;
    sb_q.push_back(mk(T_PRESS, 0));
    sb_q.push_back(mk(T_PRESS, 2));
    drain_main("after_reset", 20);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_long();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
